fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset when FETCH_RESET_VECTOR_EN is undefined.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 imem_rd  output  1  instruction-memory read request this cycle.
REQ-005 imem_addr  output  32  word address of request; 16-bit words.
REQ-006 imem_data  input  16  read data, valid exactly one cycle after imem_rd.
REQ-007 redirect_valid  input  1  branch/jump/interrupt redirect from later stage.
REQ-008 redirect_pc  input  32  target PC, used when redirect_valid=1.
REQ-009 halt  input  1  stop issuing new reads while high.
REQ-010 out_valid  output  1  out_instr/out_pc hold an instruction for the IF/ID register.
REQ-011 out_ready  input  1  IF/ID register accepts this cycle; transfer when out_valid&&out_ready.
REQ-012 out_instr  output  16  fetched instruction word.
REQ-013 out_pc  output  32  address out_instr was fetched from.

Function
REQ-014 Shall hold PC register, 2-entry FIFO of {pc,instr}, one in-flight flag with its pc.
REQ-015 States: BOOT, VEC_LO, VEC_HI, RUN; outputs only come from FIFO head.
REQ-016 In RUN shall assert imem_rd with imem_addr=PC when !halt and !redirect_valid and (fifo_count + inflight) < 2, computed with the same-cycle pop counted as freed.
REQ-017 Each issued read shall increment PC by 1, wrapping 32'hFFFF_FFFF -> 0.
REQ-018 Data returning one cycle after issue shall be pushed into FIFO with the issue PC; read-to-out_valid latency = 2 cycles with empty FIFO.
REQ-019 Simultaneous push and pop shall keep count unchanged; FIFO never overflows (credit rule REQ-016).
REQ-020 out_valid=1 iff FIFO non-empty; out_instr/out_pc stable while out_valid&&!out_ready.
REQ-021 redirect_valid: same cycle transfer (if out_valid&&out_ready) still counts; next cycle FIFO empty, in-flight return discarded, PC=redirect_pc, no read issued in redirect cycle.
REQ-022 Redirect on consecutive cycles: last one wins.
REQ-023 halt: no new reads; in-flight return still pushed; FIFO still drains; redirect still applies.

Reset
REQ-024 rst shall force: state=BOOT, FIFO empty, in-flight cleared, out_valid=0, imem_rd=0, out_instr=0, out_pc=0, imem_addr=0, PC=RESET_PC.
REQ-025 rst mid-operation shall abandon in-flight reads; their data ignored.
REQ-026 rst dominates redirect_valid and halt.

Configuration
REQ-027 Macro FETCH_RESET_VECTOR_EN defined: BOOT -> VEC_LO reads addr 0, VEC_HI reads addr 1, PC = {M[1],M[0]} then RUN; 4 cycles after rst release first program read.
REQ-028 Macro undefined: BOOT -> RUN on first cycle after reset, PC=RESET_PC; VEC_LO/VEC_HI unreachable.
REQ-029 redirect_valid during VEC_LO/VEC_HI shall be ignored.

Structure
REQ-030 Shared package holds state enum, PC_W=32, INSTR_W=16, FIFO_DEPTH=2.
REQ-031 FIFO shall be sub-module fetch_fifo (2-entry, push/pop/count, flush input).

Verification
REQ-032 Macro off, RESET_PC=0x20, out_ready=1, M[0x20..]=A,B,C -> out_pc 0x20,0x21,0x22 with A,B,C on consecutive cycles from cycle 3.
REQ-033 Macro on, M[0]=0x0040, M[1]=0x0000 -> first imem_addr in RUN = 0x40.
REQ-034 out_ready=0 for 5 cycles -> count saturates at 2, imem_rd=0, out_instr unchanged; release -> no word lost/duplicated.
REQ-035 Redirect to 0x100 with one in-flight and FIFO full -> next out_pc=0x100, stale words never appear.
REQ-036 PC=0xFFFF_FFFF -> next issued address 0x0000_0000.
REQ-037 rst asserted while in-flight and FIFO=1 -> next cycle out_valid=0, all outputs at REQ-024 values.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and sizes for the fetch stage
package fetch_pkg;

    localparam int PC_W       = 32;
    localparam int INSTR_W    = 16;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_VEC_LO,
        ST_VEC_HI,
        ST_RUN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry {pc,instr} queue between fetch and IF/ID
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    output logic [1:0]         count,
    output logic [PC_W-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    logic [PC_W-1:0]    pc_mem    [FIFO_DEPTH];
    logic [INSTR_W-1:0] instr_mem [FIFO_DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign push_ok    = push && (count != FULL);
    assign pop_ok     = pop && (count != 2'd0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with credit-limited reads; FETCH_RESET_VECTOR_EN loads PC from M[1:0]
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    fetch_state_t       state;
    fetch_state_t       state_n;
    logic [PC_W-1:0]    pc_q;
    logic               inflight;
    logic [PC_W-1:0]    inflight_pc;
    logic [INSTR_W-1:0] vec_lo;
    logic               vec_wait;
    logic [1:0]         fifo_count;
    logic               pop;
    logic               push;
    logic               redir_take;
    logic               issue;
    logic [2:0]         occupancy;

    assign out_valid  = (fifo_count != 2'd0);
    assign pop        = out_valid && out_ready;
    assign redir_take = redirect_valid && (state == ST_RUN) && !vec_wait;
    assign push       = inflight && !redir_take;

    // A word leaving this cycle frees its slot for a read issued this cycle.
    assign occupancy  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue      = (state == ST_RUN) && !vec_wait && !rst && !halt
                        && !redirect_valid && (occupancy < 3'(FIFO_DEPTH));

    always_comb begin
        state_n   = state;
        imem_rd   = 1'b0;
        imem_addr = '0;
        case (state)
            ST_BOOT: begin
`ifdef FETCH_RESET_VECTOR_EN
                state_n = ST_VEC_LO;
`else
                state_n = ST_RUN;
`endif
            end
            ST_VEC_LO: begin
                imem_rd   = !rst;
                imem_addr = 32'd0;
                state_n   = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                imem_rd   = !rst;
                imem_addr = 32'd1;
                state_n   = ST_RUN;
            end
            ST_RUN: begin
                imem_rd   = issue;
                imem_addr = issue ? pc_q : '0;
            end
            default: state_n = ST_BOOT;
        endcase
    end

    // vec_wait marks the first RUN cycle, when the high vector half returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            vec_lo      <= '0;
            vec_wait    <= 1'b0;
        end else begin
            state    <= state_n;
            inflight <= issue;
            vec_wait <= (state == ST_VEC_HI);
            if (state == ST_VEC_HI) begin
                vec_lo <= imem_data;
            end
            if (issue) begin
                inflight_pc <= pc_q;
            end
            if (redir_take) begin
                pc_q <= redirect_pc;
            end else if (vec_wait) begin
                pc_q <= {imem_data, vec_lo};
            end else if (issue) begin
                pc_q <= pc_q + 32'd1;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redir_take),
        .push       (push),
        .push_pc    (inflight_pc),
        .push_instr (imem_data),
        .pop        (pop),
        .count      (fifo_count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against an ideal sequential-PC stream model
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0020;
`ifdef FETCH_RESET_VECTOR_EN
    localparam int FIRST_LAT = 6;
`else
    localparam int FIRST_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [15:0] imem_data = 16'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A5A;
    endfunction

    function automatic logic [31:0] start_pc();
`ifdef FETCH_RESET_VECTOR_EN
        return {mem_word(32'd1), mem_word(32'd0)};
`else
        return RST_PC;
`endif
    endfunction

    // Instruction memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        imem_data <= imem_rd ? mem_word(imem_addr) : 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: the expected stream is consecutive PCs from the last reset/redirect target.
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc = RST_PC;
    logic        prev_rst = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] hold_pc;
    logic [15:0] hold_instr;

    always @(negedge clk) begin
        logic [31:0] e;
        if (prev_rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_imem_rd", 32'(imem_rd), 32'd0);
            chk("rst_imem_addr", imem_addr, 32'd0);
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_out_instr", 32'(out_instr), 32'd0);
        end
        if (prev_hold) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, hold_pc);
            chk("stall_instr", 32'(out_instr), 32'(hold_instr));
        end
        if (!rst && (halt || redirect_valid)) begin
            chk("no_rd_halt_redirect", 32'(imem_rd), 32'd0);
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd1;
        end
        if (!rst && out_valid && out_ready) begin
            e = exp_q.pop_front();
            chk("xfer_pc", out_pc, e);
            chk("xfer_instr", 32'(out_instr), 32'(mem_word(e)));
            n_xfer++;
        end
        if (rst) begin
            exp_q.delete();
            gen_pc = start_pc();
        end else if (redirect_valid) begin
            exp_q.delete();
            gen_pc = redirect_pc;
        end
        prev_hold  = !rst && !redirect_valid && out_valid && !out_ready;
        hold_pc    = out_pc;
        hold_instr = out_instr;
        prev_rst   = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int exp_n);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(exp_n));
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int quiet;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_valid("first_latency", FIRST_LAT);
        chk("first_pc", out_pc, start_pc());
        repeat (10) tick();

        // Reset with one word buffered and one read in flight.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();

        out_ready = 1'b0;
        repeat (6) tick();
        chk("sat_valid", 32'(out_valid), 32'd1);
        chk("sat_no_rd", 32'(imem_rd), 32'd0);
        out_ready = 1'b1;
        repeat (5) tick();

        out_ready = 1'b0;
        repeat (2) tick();
        out_ready = 1'b1;
        redirect_to(32'h0000_0100);
        wait_valid("redirect_latency", 2);
        chk("redirect_pc", out_pc, 32'h0000_0100);
        repeat (4) tick();

        redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        tick();
        redirect_to(32'h0000_0600);
        repeat (6) tick();

        redirect_to(32'hFFFF_FFFE);
        repeat (8) tick();

        halt = 1'b1;
        repeat (5) tick();
        halt = 1'b0;

        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(9) < 7);
            rst            = ($urandom_range(199) == 0);
            halt           = (quiet == 0) && ($urandom_range(9) == 0);
            redirect_valid = (quiet == 0) && !halt && ($urandom_range(29) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(3)) : $urandom;
            if (rst) quiet = 8;
            else if (quiet > 0) quiet--;
            tick();
        end
        rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        repeat (3) tick();
        chk("transfers_seen", 32'(n_xfer > 500), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
